// File: rtl/lzc_pkg.sv
// Shared types and elaboration-time helpers for the pipelined zero counter.
package lzc_pkg;

  // Per-transaction count direction
  typedef enum logic {
    LZC_MODE_LZ = 1'b0,
    LZC_MODE_TZ = 1'b1
  } lzc_mode_e;

  // Count width: must hold the value w itself for an all-zero operand
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // First search level handled by stage s (ceil(levels*s/stages));
  // stage s covers [stage_lvl_lo(s), stage_lvl_lo(s+1))
  function automatic int stage_lvl_lo(input int levels, input int stages, input int s);
    return (levels * s + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/lzc_pipe_stage.sv
// One pipeline stage: a slice of the binary-search levels followed by a
// valid/ready register that collapses bubbles.
module lzc_pipe_stage
  import lzc_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LVL_LO     = 0,
  parameter int LVL_HI     = 1,
  parameter int TAG_WIDTH  = 4,
  localparam int CNT_W     = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0]      in_cnt,
  input  lzc_mode_e             in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_cnt,
  output lzc_mode_e             out_mode,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int L    = $clog2(DATA_WIDTH);
  localparam int NLVL = LVL_HI - LVL_LO;

  // Working value and partial count after each level of this stage
  logic [DATA_WIDTH-1:0] lvl_data [0:NLVL];
  logic [CNT_W-1:0]      lvl_cnt  [0:NLVL];

  assign lvl_data[0] = in_data;
  assign lvl_cnt[0]  = in_cnt;

  // The current search window always sits at the MSB end of the working
  // value, so each level only inspects the top SH bits.
  for (genvar gi = 0; gi < NLVL; gi++) begin : g_lvl
    localparam int LVL = LVL_LO + gi;
    localparam int SH  = DATA_WIDTH >> (LVL + 1);
    localparam logic [CNT_W-1:0] CNT_BIT = CNT_W'(1) << (L - 1 - LVL);
    logic upper_zero;
    assign upper_zero       = (lvl_data[gi][DATA_WIDTH-1 -: SH] == '0);
    assign lvl_data[gi + 1] = upper_zero ? (lvl_data[gi] << SH) : lvl_data[gi];
    assign lvl_cnt[gi + 1]  = upper_zero ? (lvl_cnt[gi] | CNT_BIT) : lvl_cnt[gi];
  end

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CNT_W-1:0]      cnt_reg;
  lzc_mode_e             mode_reg;
  logic [TAG_WIDTH-1:0]  tag_reg;

  // Accept when empty or when the downstream stage takes our content;
  // depends only on state and out_ready, never on in_valid.
  assign in_ready = !valid_reg || out_ready;

  // Stage register: payload is captured only on an actual transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= LZC_MODE_LZ;
      tag_reg   <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= lvl_data[NLVL];
        cnt_reg  <= lvl_cnt[NLVL];
        mode_reg <= in_mode;
        tag_reg  <= in_tag;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_cnt   = cnt_reg;
  assign out_mode  = mode_reg;
  assign out_tag   = tag_reg;

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading/trailing-zero counter with normaliser. TZ is handled by
// bit-reversing the operand on entry and the normalised value on exit, so the
// search core only ever counts leading zeros.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_WIDTH   = 4,
  localparam int CNT_W      = cnt_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_is_zero,
  output logic [DATA_WIDTH-1:0] out_norm,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int L = $clog2(DATA_WIDTH);

  // Index 0 is the input boundary, index PIPE_STAGES the output boundary
  logic                  s_valid [0:PIPE_STAGES];
  logic                  s_ready [0:PIPE_STAGES];
  logic [DATA_WIDTH-1:0] s_data  [0:PIPE_STAGES];
  logic [CNT_W-1:0]      s_cnt   [0:PIPE_STAGES];
  lzc_mode_e             s_mode  [0:PIPE_STAGES];
  logic [TAG_WIDTH-1:0]  s_tag   [0:PIPE_STAGES];

  logic [DATA_WIDTH-1:0] in_rev;
  logic [DATA_WIDTH-1:0] norm_rev;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
    assign in_rev[gi]   = in_data[DATA_WIDTH-1-gi];
    assign norm_rev[gi] = s_data[PIPE_STAGES][DATA_WIDTH-1-gi];
  end

  assign s_valid[0] = in_valid;
  assign in_ready   = s_ready[0];
  assign s_mode[0]  = lzc_mode_e'(in_mode);
  assign s_data[0]  = (s_mode[0] == LZC_MODE_TZ) ? in_rev : in_data;
  assign s_cnt[0]   = '0;
  assign s_tag[0]   = in_tag;

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    lzc_pipe_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .LVL_LO     (stage_lvl_lo(L, PIPE_STAGES, gi)),
      .LVL_HI     (stage_lvl_lo(L, PIPE_STAGES, gi + 1)),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_valid[gi]),
      .in_ready  (s_ready[gi]),
      .in_data   (s_data[gi]),
      .in_cnt    (s_cnt[gi]),
      .in_mode   (s_mode[gi]),
      .in_tag    (s_tag[gi]),
      .out_valid (s_valid[gi+1]),
      .out_ready (s_ready[gi+1]),
      .out_data  (s_data[gi+1]),
      .out_cnt   (s_cnt[gi+1]),
      .out_mode  (s_mode[gi+1]),
      .out_tag   (s_tag[gi+1])
    );
  end

  assign s_ready[PIPE_STAGES] = out_ready;

  // After a full search a nonzero operand has its MSB set; a zero operand
  // stays zero with every count bit set (W-1), so promote that case to W.
  // Gated by valid so the reset state reports is_zero = 0.
  assign out_valid   = s_valid[PIPE_STAGES];
  assign out_is_zero = s_valid[PIPE_STAGES] && !s_data[PIPE_STAGES][DATA_WIDTH-1];
  assign out_count   = out_is_zero ? CNT_W'(DATA_WIDTH) : s_cnt[PIPE_STAGES];
  assign out_norm    = (s_mode[PIPE_STAGES] == LZC_MODE_TZ) ? norm_rev : s_data[PIPE_STAGES];
  assign out_tag     = s_tag[PIPE_STAGES];

endmodule
